conv_sequencer: RTL and testbench

Parametrised convolution sequencer for the accelerator datapath. On a start handshake it preloads up to MAX_KERNELS kernels from kernel SRAM into the per-kernel shift registers. It then walks every output window of a size_act x size_act activation map with runtime kernel size and stride, streaming window addresses to activation SRAM and handshaking one PE-array computation per window. It replaces the fixed 5x5x6 sequencer and adds runtime kernel count, stride, start/busy/done, abort and a config-error flag.

---
 rtl/conv_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_conv_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Convolution sequencer: preloads N kernels into per-kernel shift registers, then walks
// every KxK window of a WxW activation map at stride S, one PE-array handshake per window.
module conv_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int SIZE_W      = 8,
   parameter int MAX_KERNELS = 6,
   parameter int CNT_W       = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [SIZE_W-1:0]      i_size_act,
   input  logic [SIZE_W-1:0]      i_size_kernel,
   input  logic [CNT_W-1:0]       i_num_kernels,
   input  logic [1:0]             i_stride,
   input  logic                   i_pe_done,
   output logic [ADDR_W-1:0]      o_address_kernel,
   output logic                   o_enable_kernel_sram,
   output logic [MAX_KERNELS-1:0] o_enable_kernel_shift_reg,
   output logic [ADDR_W-1:0]      o_address_act,
   output logic                   o_enable_act_sram,
   output logic                   o_act_valid,
   output logic                   o_enable_pe_array,
   output logic [MAX_KERNELS-1:0] o_enable_pe_array_line,
   output logic [SIZE_W-1:0]      o_win_row,
   output logic [SIZE_W-1:0]      o_win_col,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_cfg_err
);
   localparam int SW1 = SIZE_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD_K, S_FETCH_WIN, S_COMPUTE, S_FINISH} state_t;

   state_t                 r_state, w_next;
   logic [SIZE_W-1:0]      r_w, r_k, r_i, r_j, r_row, r_col;
   logic [CNT_W-1:0]       r_n, r_kidx;
   logic [1:0]             r_s;
   logic [ADDR_W-1:0]      r_kk, r_total, r_kaddr, r_kin;
   logic                   r_kdrain, r_act_valid, r_pulsed, r_cfg_err;
   logic [MAX_KERNELS-1:0] r_shift, r_line, w_mask;

   logic                   w_cfg_bad, w_ksram, w_fetch, w_k_last, w_fetch_last;
   logic                   w_pe_pulse, w_pe_accept, w_col_wrap, w_row_wrap;
   logic [SIZE_W-1:0]      w_lim;
   logic [SW1-1:0]         w_col_nx, w_row_nx;
   logic [ADDR_W-1:0]      w_kk, w_total, w_act_addr;

   assign w_cfg_bad = (i_size_kernel == '0) || (i_size_kernel > i_size_act) ||
                      (i_num_kernels == '0) || (i_num_kernels > CNT_W'(MAX_KERNELS)) ||
                      (i_stride == 2'd0);
   assign w_kk      = ADDR_W'(i_size_kernel) * ADDR_W'(i_size_kernel);
   assign w_total   = w_kk * ADDR_W'(i_num_kernels);

   assign w_ksram      = (r_state == S_LOAD_K) && !r_kdrain;
   assign w_fetch      = (r_state == S_FETCH_WIN);
   assign w_k_last     = (r_kaddr == r_total - ADDR_W'(1));
   assign w_fetch_last = (r_i == r_k - SIZE_W'(1)) && (r_j == r_k - SIZE_W'(1));
   assign w_act_addr   = ADDR_W'(r_row + r_i) * ADDR_W'(r_w) + ADDR_W'(r_col + r_j);

   // The PE start fires once the last activation word has landed; pe_done is only
   // meaningful after that pulse.
   assign w_pe_pulse  = (r_state == S_COMPUTE) && !r_act_valid && !r_pulsed;
   assign w_pe_accept = (r_state == S_COMPUTE) && r_pulsed && i_pe_done && !i_abort;

   assign w_lim      = r_w - r_k;
   assign w_col_nx   = {1'b0, r_col} + SW1'(r_s);
   assign w_row_nx   = {1'b0, r_row} + SW1'(r_s);
   assign w_col_wrap = w_col_nx > {1'b0, w_lim};
   assign w_row_wrap = w_row_nx > {1'b0, w_lim};

   always_comb begin
      w_mask = '0;
      for (int j = 0; j < MAX_KERNELS; j++)
         w_mask[j] = (CNT_W'(j) < i_num_kernels);
   end

   always_comb begin
      w_next                    = r_state;
      o_address_kernel          = w_ksram ? r_kaddr : '0;
      o_enable_kernel_sram      = w_ksram;
      o_enable_kernel_shift_reg = r_shift;
      o_address_act             = w_fetch ? w_act_addr : '0;
      o_enable_act_sram         = w_fetch;
      o_act_valid               = r_act_valid;
      o_enable_pe_array         = w_pe_pulse;
      o_enable_pe_array_line    = r_line;
      o_win_row                 = r_row;
      o_win_col                 = r_col;
      o_busy                    = (r_state != S_IDLE);
      o_done                    = (r_state == S_FINISH);
      o_cfg_err                 = r_cfg_err;
      case (r_state)
         S_IDLE:      if (i_start) w_next = w_cfg_bad ? S_FINISH : S_LOAD_K;
         S_LOAD_K:    if (r_kdrain) w_next = S_FETCH_WIN;
         S_FETCH_WIN: if (w_fetch_last) w_next = S_COMPUTE;
         S_COMPUTE:   if (w_pe_accept) w_next = (w_col_wrap && w_row_wrap) ? S_FINISH : S_FETCH_WIN;
         S_FINISH:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
      if (i_abort && r_state != S_IDLE) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_w         <= '0;
         r_k         <= '0;
         r_n         <= '0;
         r_s         <= '0;
         r_kk        <= '0;
         r_total     <= '0;
         r_kaddr     <= '0;
         r_kin       <= '0;
         r_kidx      <= '0;
         r_kdrain    <= 1'b0;
         r_shift     <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_act_valid <= 1'b0;
         r_pulsed    <= 1'b0;
         r_line      <= '0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_shift     <= (w_ksram && !i_abort) ? (MAX_KERNELS'(1) << r_kidx) : '0;
         r_act_valid <= w_fetch && !i_abort;
         if (w_next == S_FINISH || w_next == S_IDLE) r_line <= '0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_w       <= i_size_act;
               r_k       <= i_size_kernel;
               r_n       <= i_num_kernels;
               r_s       <= i_stride;
               r_kk      <= w_kk;
               r_total   <= w_total;
               r_cfg_err <= w_cfg_bad;
               r_kaddr   <= '0;
               r_kin     <= '0;
               r_kidx    <= '0;
               r_kdrain  <= 1'b0;
               r_i       <= '0;
               r_j       <= '0;
               r_row     <= '0;
               r_col     <= '0;
               r_pulsed  <= 1'b0;
               if (!w_cfg_bad) r_line <= w_mask;
            end
            S_LOAD_K: if (!r_kdrain) begin
               r_kaddr <= r_kaddr + ADDR_W'(1);
               if (r_kin == r_kk - ADDR_W'(1)) begin
                  r_kin  <= '0;
                  r_kidx <= r_kidx + CNT_W'(1);
               end else begin
                  r_kin  <= r_kin + ADDR_W'(1);
               end
               if (w_k_last) r_kdrain <= 1'b1;
            end
            S_FETCH_WIN: begin
               r_pulsed <= 1'b0;
               if (r_j == r_k - SIZE_W'(1)) begin
                  r_j <= '0;
                  r_i <= (r_i == r_k - SIZE_W'(1)) ? '0 : r_i + SIZE_W'(1);
               end else begin
                  r_j <= r_j + SIZE_W'(1);
               end
            end
            S_COMPUTE: begin
               if (w_pe_pulse) r_pulsed <= 1'b1;
               if (w_pe_accept) begin
                  r_pulsed <= 1'b0;
                  if (w_col_wrap) begin
                     r_col <= '0;
                     if (!w_row_wrap) r_row <= w_row_nx[SIZE_W-1:0];
                  end else begin
                     r_col <= w_col_nx[SIZE_W-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: full jobs with hand-computed totals, bad configs,
// abort, and reset mid-job.
module tb_conv_sequencer;
   logic        clk, reset, i_start, i_abort, i_pe_done;
   logic [7:0]  i_size_act, i_size_kernel;
   logic [3:0]  i_num_kernels;
   logic [1:0]  i_stride;
   logic [15:0] o_address_kernel, o_address_act;
   logic        o_enable_kernel_sram, o_enable_act_sram, o_act_valid, o_enable_pe_array;
   logic [5:0]  o_enable_kernel_shift_reg, o_enable_pe_array_line;
   logic [7:0]  o_win_row, o_win_col;
   logic        o_busy, o_done, o_cfg_err;
   logic        w_any_out, w_any_en;

   int n_chk = 0;
   int n_err = 0;

   conv_sequencer dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
      .i_size_act(i_size_act), .i_size_kernel(i_size_kernel),
      .i_num_kernels(i_num_kernels), .i_stride(i_stride), .i_pe_done(i_pe_done),
      .o_address_kernel(o_address_kernel), .o_enable_kernel_sram(o_enable_kernel_sram),
      .o_enable_kernel_shift_reg(o_enable_kernel_shift_reg),
      .o_address_act(o_address_act), .o_enable_act_sram(o_enable_act_sram),
      .o_act_valid(o_act_valid), .o_enable_pe_array(o_enable_pe_array),
      .o_enable_pe_array_line(o_enable_pe_array_line),
      .o_win_row(o_win_row), .o_win_col(o_win_col),
      .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign w_any_out = |{o_address_kernel, o_enable_kernel_sram, o_enable_kernel_shift_reg,
                        o_address_act, o_enable_act_sram, o_act_valid, o_enable_pe_array,
                        o_enable_pe_array_line, o_win_row, o_win_col, o_busy, o_done, o_cfg_err};
   assign w_any_en  = |{o_enable_kernel_sram, o_enable_kernel_shift_reg, o_enable_act_sram,
                        o_act_valid, o_enable_pe_array};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_start(input int w, input int k, input int n, input int s);
      @(negedge clk);
      i_size_act = 8'(w); i_size_kernel = 8'(k); i_num_kernels = 4'(n); i_stride = 2'(s);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Runs one job to completion, answering each PE pulse with pe_done 3 cycles later.
   task automatic run_job(input string nm, input int w, input int k, input int n, input int s,
                          input int exp_kreads, input int exp_win, input logic [5:0] exp_mask,
                          input int exp_last_addr);
      int kcnt = 0, kfirst = 0, klast = 0, kerr = 0, serr = 0, aerr = 0, verr = 0, merr = 0;
      int pe_cnt = 0, pe_err = 0, done_cnt = 0, win_cnt = 0, wr = 0, wc = 0, fi = 0, fj = 0;
      int last_addr = -1, pe_timer = 0, exp_a;
      logic prev_ken = 0, prev_aen = 0, prev_av = 0, fin = 0;
      logic [15:0] prev_kaddr = 0;
      logic [5:0]  exp_shift;
      do_start(w, k, n, s);
      chk({nm, "_cfg_err"}, o_cfg_err, 0);
      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         i_pe_done = 1'b0; i_start = 1'b0; i_size_kernel = 8'(k);
         exp_shift = prev_ken ? (6'd1 << (int'(prev_kaddr) / (k * k))) : 6'd0;
         if (o_enable_kernel_shift_reg !== exp_shift) serr++;
         if (o_enable_kernel_sram) begin
            if (int'(o_address_kernel) != kcnt) kerr++;
            if (kcnt == 0) kfirst = cyc;
            klast = cyc;
            kcnt++;
            if (kcnt == 4) i_pe_done = 1'b1;
         end
         prev_ken = o_enable_kernel_sram; prev_kaddr = o_address_kernel;
         if (o_act_valid !== prev_aen) verr++;
         if (o_enable_act_sram) begin
            exp_a = (wr + fi) * w + wc + fj;
            if (fi == 0 && fj == 0) last_addr = int'(o_address_act);
            if (int'(o_address_act) != exp_a) aerr++;
            if (fj == k - 1) begin fj = 0; fi = (fi == k - 1) ? 0 : fi + 1; end
            else fj++;
         end
         prev_aen = o_enable_act_sram;
         if (o_enable_pe_array) begin
            pe_cnt++;
            if (!(prev_av && !o_act_valid)) pe_err++;
            pe_timer = 3;
            if (pe_cnt == 1) begin i_start = 1'b1; i_size_kernel = 8'd1; end
         end else if (pe_timer > 0) begin
            pe_timer--;
            if (pe_timer == 0) begin
               i_pe_done = 1'b1; win_cnt++;
               wc += s;
               if (wc > w - k) begin wc = 0; wr += s; end
            end
         end
         prev_av = o_act_valid;
         if (o_done) begin
            done_cnt++; fin = 1;
            if (o_enable_pe_array_line !== 6'd0) merr++;
         end else if (o_busy && o_enable_pe_array_line !== exp_mask) merr++;
         @(negedge clk);
      end
      i_pe_done = 1'b0; i_start = 1'b0;
      chk({nm, "_finished"}, fin, 1);
      chk({nm, "_idle_after"}, {o_busy, o_done}, 0);
      chk({nm, "_kreads"}, kcnt, exp_kreads);
      chk({nm, "_kaddr_seq"}, kerr, 0);
      chk({nm, "_kcontig"}, klast - kfirst + 1, exp_kreads);
      chk({nm, "_shift_seq"}, serr, 0);
      chk({nm, "_act_addr"}, aerr, 0);
      chk({nm, "_act_valid"}, verr, 0);
      chk({nm, "_pe_pulses"}, pe_cnt, exp_win);
      chk({nm, "_pe_timing"}, pe_err, 0);
      chk({nm, "_windows"}, win_cnt, exp_win);
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_line_mask"}, merr, 0);
      chk({nm, "_last_win"}, last_addr, exp_last_addr);
   endtask

   task automatic run_bad(input string nm, input int w, input int k, input int n, input int s);
      do_start(w, k, n, s);
      chk({nm, "_done"}, o_done, 1);
      chk({nm, "_err"}, o_cfg_err, 1);
      chk({nm, "_no_en0"}, w_any_en, 0);
      @(negedge clk);
      chk({nm, "_done_1cyc"}, {o_busy, o_done}, 0);
      chk({nm, "_err_sticky"}, o_cfg_err, 1);
      chk({nm, "_no_en1"}, w_any_en, 0);
   endtask

   task automatic watch_no_done(input string nm);
      int d = 0;
      for (int c = 0; c < 4; c++) begin
         if (o_done || o_busy) d++;
         @(negedge clk);
      end
      chk({nm, "_quiet"}, d, 0);
   endtask

   initial begin
      int found;
      reset = 1'b0; i_start = 0; i_abort = 0; i_pe_done = 0;
      i_size_act = 0; i_size_kernel = 0; i_num_kernels = 0; i_stride = 0;
      #3 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", w_any_out, 0);
      reset = 1'b0;

      run_job("j1", 8, 5, 6, 1, 150, 16, 6'b111111, 27);
      run_job("j2", 7, 3, 2, 2, 18, 9, 6'b000011, 32);
      run_job("j3", 4, 4, 1, 3, 16, 1, 6'b000001, 0);

      run_bad("bad_k", 8, 9, 6, 1);
      run_bad("bad_n0", 8, 5, 0, 1);
      run_bad("bad_s0", 8, 5, 6, 0);
      run_bad("bad_n7", 8, 5, 7, 1);

      // abort in LOAD_K
      do_start(8, 5, 6, 1);
      repeat (10) @(negedge clk);
      chk("abk_loading", o_enable_kernel_sram, 1);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("abk_idle", {o_busy, o_done, o_enable_kernel_sram}, 0);
      chk("abk_shift", o_enable_kernel_shift_reg, 0);
      chk("abk_line", o_enable_pe_array_line, 0);
      watch_no_done("abk");
      run_job("post_abk", 4, 4, 1, 3, 16, 1, 6'b000001, 0);

      // abort coinciding with pe_done in COMPUTE
      do_start(7, 3, 2, 2);
      found = 0;
      for (int c = 0; c < 2000 && found == 0; c++) begin
         if (o_enable_pe_array) found = 1;
         else @(negedge clk);
      end
      chk("abc_pe_seen", found, 1);
      repeat (2) @(negedge clk);
      i_pe_done = 1'b1; i_abort = 1'b1;
      @(negedge clk);
      i_pe_done = 1'b0; i_abort = 1'b0;
      chk("abc_idle", {o_busy, o_done, o_act_valid, o_enable_pe_array, o_enable_act_sram}, 0);
      watch_no_done("abc");
      run_job("post_abc", 7, 3, 2, 2, 18, 9, 6'b000011, 32);

      // asynchronous reset during FETCH_WIN
      do_start(7, 3, 2, 2);
      found = 0;
      for (int c = 0; c < 2000 && found == 0; c++) begin
         if (o_enable_act_sram) found = 1;
         else @(negedge clk);
      end
      chk("rst_fetch_seen", found, 1);
      #2 reset = 1'b1;
      #1 chk("rst_mid_outputs", w_any_out, 0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_after_outputs", w_any_out, 0);
      run_job("post_rst", 4, 4, 1, 3, 16, 1, 6'b000001, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
